// File: rtl/keypad_pkg.sv
// ============================================================================
// Module : keypad_pkg
// Brief  : Shared types and constants for the 4x3 keypad scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  localparam int NCOL = 3;
  localparam int NROW = 4;
  localparam int NKEY = NROW * NCOL;

  // Snapshot bit index is row*NCOL + col.
  localparam logic [3:0] KEY_STAR   = 4'd9;
  localparam logic [3:0] KEY_HASH   = 4'd11;
  localparam logic [3:0] DIGIT_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONFIRM  = 2'd1,
    ST_HELD     = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  // Nibble i holds the digit printed on snapshot key i (F = not a digit).
  localparam logic [NKEY*4-1:0] DIGIT_LUT = {
    4'hF, 4'h0, 4'hF,
    4'h9, 4'h8, 4'h7,
    4'h6, 4'h5, 4'h4,
    4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_digit(input logic [3:0] idx);
    logic [3:0] d;
    d = DIGIT_NONE;
    if (int'(idx) < NKEY) d = DIGIT_LUT[int'(idx)*4 +: 4];
    return d;
  endfunction

  // Index of the lowest set key; only meaningful when exactly one bit is set.
  function automatic logic [3:0] key_index(input logic [NKEY-1:0] s);
    logic [3:0] idx;
    idx = '0;
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (s[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_col_scan.sv
// ============================================================================
// Module : keypad_col_scan
// Brief  : Column rotation, dwell timing and 12-bit row snapshot assembly.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      row_n,
  output logic [2:0]      col_n,
  output logic            frame_end,
  output logic [NKEY-1:0] snapshot
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] c_DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0]   r_dwell;
  logic [1:0]      r_col;
  logic [2:0]      r_col_n;
  logic [NKEY-1:0] r_snap;
  logic            w_dwell_last;
  logic [NKEY-1:0] w_snap;

  assign w_dwell_last = (r_dwell == c_DWELL_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dwell <= '0;
      r_col   <= '0;
      r_col_n <= 3'b110;
      r_snap  <= '0;
    end else if (w_dwell_last) begin
      r_dwell <= '0;
      r_snap  <= w_snap;
      r_col   <= (r_col == 2'(NCOL - 1)) ? 2'd0 : r_col + 2'd1;
      r_col_n <= {r_col_n[1:0], r_col_n[2]};
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Live rows merged over the driven column, so the frame-end view is complete.
  always_comb begin
    w_snap = r_snap;
    for (int r = 0; r < NROW; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        if (r_col == 2'(c)) w_snap[r*NCOL + c] = ~row_n[r];
      end
    end
  end

  assign col_n     = r_col_n;
  assign snapshot  = w_snap;
  assign frame_end = w_dwell_last && (r_col == 2'(NCOL - 1));

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module : keypad_scanner
// Brief  : Debounced 4x3 keypad to one-hot digit bus; optional '#' close
//          strobe enabled by defining CLOSE_KEY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [9:0] tenkey,
  output logic       close
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] c_DEB = CW'(DEBOUNCE);
  localparam logic [CW-1:0] c_ONE = CW'(1);

  logic            w_frame_end;
  logic [NKEY-1:0] w_snap;

  state_t          r_state;
  logic [NKEY-1:0] r_cand;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_zero;
  logic [9:0]      r_tenkey;
  logic            r_close;

  logic            w_single;
  logic [3:0]      w_idx;
  logic [3:0]      w_digit;
  state_t          w_acc_state;
  logic [9:0]      w_acc_tenkey;
  logic            w_acc_close;
  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_zero_inc;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .frame_end (w_frame_end),
    .snapshot  (w_snap)
  );

  // Outcome of accepting the current snapshot once it has been stable long enough.
  always_comb begin
    w_single     = (w_snap != '0) && ((w_snap & (w_snap - 12'd1)) == '0);
    w_idx        = key_index(w_snap);
    w_digit      = key_digit(w_idx);
    w_acc_state  = ST_WAIT_REL;
    w_acc_tenkey = '0;
    w_acc_close  = 1'b0;
    if (w_single && (w_idx != KEY_STAR) && (w_digit != DIGIT_NONE)) begin
      w_acc_state  = ST_HELD;
      w_acc_tenkey = 10'd1 << w_digit;
    end
`ifdef CLOSE_KEY_EN
    else if (w_single && (w_idx == KEY_HASH)) begin
      w_acc_state = ST_HELD;
      w_acc_close = 1'b1;
    end
`endif
  end

  assign w_cnt_inc  = (r_cnt  >= c_DEB) ? r_cnt  : r_cnt  + c_ONE;
  assign w_zero_inc = (r_zero >= c_DEB) ? r_zero : r_zero + c_ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_zero   <= '0;
      r_tenkey <= '0;
      r_close  <= 1'b0;
    end else begin
      r_close <= 1'b0;
      if (w_frame_end) begin
        case (r_state)
          ST_IDLE: begin
            if (w_snap != '0) begin
              r_cand <= w_snap;
              r_cnt  <= c_ONE;
              r_zero <= '0;
              if (c_ONE >= c_DEB) begin
                r_state  <= w_acc_state;
                r_tenkey <= w_acc_tenkey;
                r_close  <= w_acc_close;
              end else begin
                r_state <= ST_CONFIRM;
              end
            end
          end
          ST_CONFIRM: begin
            if (w_snap == r_cand) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc >= c_DEB) begin
                r_state  <= w_acc_state;
                r_tenkey <= w_acc_tenkey;
                r_close  <= w_acc_close;
                r_zero   <= '0;
              end
            end else if (w_snap == '0) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cand <= w_snap;
              r_cnt  <= c_ONE;
            end
          end
          ST_HELD: begin
            if (w_snap == r_cand) begin
              r_zero <= '0;
            end else if (w_snap == '0) begin
              if (w_zero_inc >= c_DEB) begin
                r_state  <= ST_IDLE;
                r_tenkey <= '0;
                r_zero   <= '0;
                r_cnt    <= '0;
              end else begin
                r_zero <= w_zero_inc;
              end
            end else begin
              // A second key while held would otherwise alias to a ghost digit.
              r_state  <= ST_WAIT_REL;
              r_tenkey <= '0;
              r_zero   <= '0;
            end
          end
          ST_WAIT_REL: begin
            r_tenkey <= '0;
            if (w_snap == '0) begin
              if (w_zero_inc >= c_DEB) begin
                r_state <= ST_IDLE;
                r_zero  <= '0;
                r_cnt   <= '0;
              end else begin
                r_zero <= w_zero_inc;
              end
            end else begin
              r_zero <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tenkey = r_tenkey;
  assign close  = r_close;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module : tb_keypad_scanner
// Brief  : Scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2);
//          close expectations follow CLOSE_KEY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 3 * SCAN_DIV;

  logic        clk;
  logic        reset;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [9:0]  tenkey;
  logic        close;

  logic [11:0] pressed;
  int          cyc;
  int          n_pass;
  int          n_total;
  bit          mon_en;
  logic [9:0]  last_tk;

  typedef struct {
    string      name;
    logic [9:0] tk;
    logic       cl;
    int         at;
  } exp_t;

  exp_t q[$];

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk    (clk),
    .reset  (reset),
    .row_n  (row_n),
    .col_n  (col_n),
    .tenkey (tenkey),
    .close  (close)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: a pressed key shorts its column drive onto its row.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3 + c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic expect_ev(input string nm, input logic [9:0] tk, input logic cl, input int at);
    exp_t e;
    e.name = nm;
    e.tk   = tk;
    e.cl   = cl;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic hold(input logic [11:0] keys, input int frames);
    pressed = keys;
    repeat (frames * FRAME) @(negedge clk);
  endtask

  // Monitor: any tenkey change or close pulse is an output event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if ((tenkey !== last_tk) || (close !== 1'b0)) begin
          n_total++;
          if (q.size() == 0) begin
            $display("FAIL unexpected_event: tenkey=%b close=%b cyc=%0d, expected no event",
                     tenkey, close, cyc);
          end else begin
            e = q.pop_front();
            if ((tenkey === e.tk) && (close === e.cl) && (cyc == e.at)) n_pass++;
            else $display("FAIL %s: tenkey=%b close=%b cyc=%0d, expected tenkey=%b close=%b cyc=%0d",
                          e.name, tenkey, close, cyc, e.tk, e.cl, e.at);
          end
        end
        last_tk = tenkey;
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    mon_en  = 1'b0;
    pressed = '0;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_col_n", 32'(col_n), 32'h6);
    check("reset_tenkey", 32'(tenkey), 32'h0);
    check("reset_close", 32'(close), 32'h0);
    last_tk = tenkey;
    mon_en  = 1'b1;
    reset   = 1'b1;

    check("scan_col0", 32'(col_n), 32'h6);
    repeat (SCAN_DIV) @(negedge clk);
    check("scan_col1", 32'(col_n), 32'h5);
    repeat (SCAN_DIV) @(negedge clk);
    check("scan_col2", 32'(col_n), 32'h3);
    repeat (SCAN_DIV) @(negedge clk);
    check("scan_wrap", 32'(col_n), 32'h6);

    // '5' steady press and release
    expect_ev("press_5", 10'b0000100000, 1'b0, cyc + 2*FRAME);
    hold(12'h010, 3);
    expect_ev("release_5", 10'b0, 1'b0, cyc + 2*FRAME);
    hold(12'h000, 3);

    // '7' bounces for a single frame
    hold(12'h040, 1);
    hold(12'h000, 3);
    check("bounce_7_tenkey", 32'(tenkey), 32'h0);

    // '1'+'2' together, release, then '0'
    hold(12'h003, 3);
    check("multi_12_tenkey", 32'(tenkey), 32'h0);
    hold(12'h000, 2);
    expect_ev("press_0", 10'b0000000001, 1'b0, cyc + 2*FRAME);
    hold(12'h400, 3);
    expect_ev("release_0", 10'b0, 1'b0, cyc + 2*FRAME);
    hold(12'h000, 3);

    // '#'
`ifdef CLOSE_KEY_EN
    expect_ev("close_hash", 10'b0, 1'b1, cyc + 2*FRAME);
`endif
    hold(12'h800, 3);
    check("hash_tenkey", 32'(tenkey), 32'h0);
    hold(12'h000, 3);

    // '9' held across a one-clock reset
    expect_ev("press_9", 10'b1000000000, 1'b0, cyc + 2*FRAME);
    hold(12'h100, 3);
    expect_ev("midreset_clear", 10'b0, 1'b0, cyc + 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midreset_col_n", 32'(col_n), 32'h6);
    expect_ev("repress_9", 10'b1000000000, 1'b0, cyc + 2*FRAME);
    hold(12'h100, 3);
    expect_ev("release_9", 10'b0, 1'b0, cyc + 2*FRAME);
    hold(12'h000, 3);

    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
